irq_nest_ctrl: RTL and testbench

IRQ_NEST_CTRL -- requirements
Module: irq_nest_ctrl

---
 rtl/irq_nest_ctrl.sv | 132 +++++++++++++
 tb/tb_irq_nest_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_nest_ctrl.sv
// Nested interrupt controller: pending capture, fixed-priority selection and a
// priority stack. Define IRQ_NEST_EDGE_EN to pend on request rising edges instead of levels.
module irq_nest_ctrl #(
   parameter int          NUM_IRQ       = 8,
   parameter int          MAX_DEPTH     = 3,
   parameter logic [15:0] VECTOR_BASE   = 16'h0010,
   parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_IRQ-1:0] i_irq_req,
   input  logic [NUM_IRQ-1:0] i_irq_mask,
   input  logic               i_int_en,
   input  logic               i_boundary,
   input  logic               i_iret_detected,
   output logic               o_irq_take,
   output logic [15:0]        o_irq_vector,
   output logic               o_in_irq,
   output logic [2:0]         o_depth,
   output logic [3:0]         o_cur_prio,
   output logic [NUM_IRQ-1:0] o_pending,
   output logic               o_iret_err
);

   logic [NUM_IRQ-1:0] pending_q, pending_d, pend_set;
   logic [3:0]         stack_q [MAX_DEPTH];
   logic [3:0]         stack_d [MAX_DEPTH];
   logic [2:0]         depth_q, depth_d;
   logic               in_irq_q;
   logic               take_q, take_d;
   logic [15:0]        vector_q, vector_d;
   logic               iret_err_q, iret_err_d;
   logic               cand_valid;
   logic [3:0]         cand_idx;
   logic [3:0]         top_prio;
   logic               eligible;
   logic               do_pop;

`ifdef IRQ_NEST_EDGE_EN
   logic [NUM_IRQ-1:0] req_hist_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) req_hist_q <= '0;
      else          req_hist_q <= i_irq_req;
   end

   assign pend_set = i_irq_req & ~req_hist_q;
`else
   assign pend_set = i_irq_req;
`endif

   // Lowest enabled pending index wins; the downward loop leaves it as the last write.
   always_comb begin
      cand_valid = 1'b0;
      cand_idx   = 4'hF;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending_q[i] && i_irq_mask[i]) begin
            cand_valid = 1'b1;
            cand_idx   = 4'(i);
         end
      end
   end

   always_comb begin
      top_prio = 4'hF;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (depth_q == 3'(i + 1)) top_prio = stack_q[i];
      end
   end

   assign eligible = cand_valid && ((depth_q == 3'd0) || (cand_idx < top_prio));
   assign do_pop   = i_iret_detected && (depth_q != 3'd0);
   assign take_d   = eligible && i_int_en && i_boundary && !i_iret_detected && !take_q
                     && (depth_q < 3'(MAX_DEPTH));

   // NOTE: combinational next-state uses blocking '=' with every output defaulted
   // first, so no latches are inferred; the registers below use '<=' only.
   always_comb begin
      pending_d  = pending_q | pend_set;
      stack_d    = stack_q;
      depth_d    = depth_q;
      vector_d   = vector_q;
      iret_err_d = iret_err_q | (i_iret_detected && (depth_q == 3'd0));
      if (take_d) begin
         // A take's clear overrides a same-cycle set of that channel.
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand_idx == 4'(i)) pending_d[i] = 1'b0;
         end
         for (int i = 0; i < MAX_DEPTH; i++) begin
            if (depth_q == 3'(i)) stack_d[i] = cand_idx;
         end
         depth_d  = depth_q + 3'd1;
         vector_d = VECTOR_BASE + 16'(cand_idx) * VECTOR_STRIDE;
      end else if (do_pop) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            if (depth_q == 3'(i + 1)) stack_d[i] = 4'hF;
         end
         depth_d = depth_q - 3'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q  <= '0;
         depth_q    <= 3'd0;
         in_irq_q   <= 1'b0;
         take_q     <= 1'b0;
         vector_q   <= 16'h0000;
         iret_err_q <= 1'b0;
         // NOTE: the stack is only a few entries, so it is reset entry by entry;
         // an empty slot reads 4'hF, which is what o_cur_prio shows at depth 0.
         for (int i = 0; i < MAX_DEPTH; i++) stack_q[i] <= 4'hF;
      end else begin
         pending_q  <= pending_d;
         depth_q    <= depth_d;
         in_irq_q   <= (depth_d != 3'd0);
         take_q     <= take_d;
         vector_q   <= vector_d;
         iret_err_q <= iret_err_d;
         for (int i = 0; i < MAX_DEPTH; i++) stack_q[i] <= stack_d[i];
      end
   end

   assign o_irq_take   = take_q;
   assign o_irq_vector = vector_q;
   assign o_in_irq     = in_irq_q;
   assign o_depth      = depth_q;
   assign o_cur_prio   = top_prio;
   assign o_pending    = pending_q;
   assign o_iret_err   = iret_err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Self-checking bench for irq_nest_ctrl: table of single-IRQ vectors, take scoreboard,
// and hand sequences for preemption, coincidence, mode, saturation and reset.
module tb_irq_nest_ctrl;

   localparam int N = 8;
`ifdef IRQ_NEST_EDGE_EN
   localparam int          MODE_TAKES = 1;
   localparam logic [13:0] MODE_TAKE_AT = 14'h0004;
   localparam logic [13:0] MODE_IRET_AT = 14'h0010;
`else
   localparam int          MODE_TAKES = 4;
   localparam logic [13:0] MODE_TAKE_AT = 14'h0924;
   localparam logic [13:0] MODE_IRET_AT = 14'h2490;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] i_irq_req, i_irq_mask;
   logic         i_int_en, i_boundary, i_iret;

   logic         take, in_irq, iret_err;
   logic [15:0]  vec;
   logic [2:0]   depth;
   logic [3:0]   prio;
   logic [N-1:0] pend;

   logic         d2_take, d2_in_irq, d2_iret_err;
   logic [15:0]  d2_vec;
   logic [2:0]   d2_depth;
   logic [3:0]   d2_prio;
   logic [N-1:0] d2_pend;

   always #5 clk = ~clk;

   irq_nest_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_irq_req(i_irq_req), .i_irq_mask(i_irq_mask),
      .i_int_en(i_int_en), .i_boundary(i_boundary), .i_iret_detected(i_iret),
      .o_irq_take(take), .o_irq_vector(vec), .o_in_irq(in_irq), .o_depth(depth),
      .o_cur_prio(prio), .o_pending(pend), .o_iret_err(iret_err)
   );

   irq_nest_ctrl #(.MAX_DEPTH(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_irq_req(i_irq_req), .i_irq_mask(i_irq_mask),
      .i_int_en(i_int_en), .i_boundary(i_boundary), .i_iret_detected(i_iret),
      .o_irq_take(d2_take), .o_irq_vector(d2_vec), .o_in_irq(d2_in_irq), .o_depth(d2_depth),
      .o_cur_prio(d2_prio), .o_pending(d2_pend), .o_iret_err(d2_iret_err)
   );

   typedef struct {
      logic [15:0] vec;
      logic [3:0]  prio;
   } exp_t;

   typedef struct {
      int          ch;
      logic [N-1:0] mask;
      logic        int_en;
      logic        boundary;
      logic        take_now;
      logic [15:0] vec;
   } tv_t;

   exp_t sb_q[$];
   tv_t  tbl[6];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   take_cnt = 0;
   logic sb_en = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v, input logic [3:0] p);
      exp_t e;
      e.vec  = v;
      e.prio = p;
      sb_q.push_back(e);
   endtask

   task automatic pulse_iret();
      i_iret = 1'b1;
      tick();
      i_iret = 1'b0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      i_irq_req = '0;
      i_iret    = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Every take on the main instance must match the oldest queued expectation.
   always @(negedge clk) begin
      if (sb_en && rst_n && take) begin
         exp_t e;
         take_cnt++;
         check("sb_take_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_take_vector", 32'(vec), 32'(e.vec));
            check("sb_take_prio", 32'(prio), 32'(e.prio));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{3, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h001C};
      tbl[1] = '{0, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h0010};
      tbl[2] = '{7, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h002C};
      tbl[3] = '{5, 8'hDF, 1'b1, 1'b1, 1'b0, 16'h0024};
      tbl[4] = '{6, 8'hFF, 1'b0, 1'b1, 1'b0, 16'h0028};
      tbl[5] = '{1, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h0014};

      rst_n = 1'b0;
      i_irq_req = '0; i_irq_mask = '1; i_int_en = 1'b1; i_boundary = 1'b1; i_iret = 1'b0;
      #1;
      check("rst_take", 32'(take), 32'd0);
      check("rst_vector", 32'(vec), 32'h0000);
      check("rst_depth", 32'(depth), 32'd0);
      check("rst_in_irq", 32'(in_irq), 32'd0);
      check("rst_cur_prio", 32'(prio), 32'hF);
      check("rst_pending", 32'(pend), 32'd0);
      check("rst_iret_err", 32'(iret_err), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single-IRQ vectors, some gated by mask/int_en/boundary until released.
      for (int k = 0; k < 6; k++) begin
         i_irq_mask = tbl[k].mask;
         i_int_en   = tbl[k].int_en;
         i_boundary = tbl[k].boundary;
         i_irq_req  = 8'h01 << tbl[k].ch;
         tick();
         i_irq_req = '0;
         check("tbl_pend_set", 32'(pend[3'(tbl[k].ch)]), 32'd1);
         if (tbl[k].take_now) push(tbl[k].vec, 4'(tbl[k].ch));
         tick();
         if (!tbl[k].take_now) begin
            check("tbl_gated_take", 32'(take), 32'd0);
            check("tbl_gated_pend", 32'(pend[3'(tbl[k].ch)]), 32'd1);
            i_irq_mask = '1; i_int_en = 1'b1; i_boundary = 1'b1;
            push(tbl[k].vec, 4'(tbl[k].ch));
            tick();
         end
         check("tbl_take", 32'(take), 32'd1);
         check("tbl_vector", 32'(vec), 32'(tbl[k].vec));
         check("tbl_depth", 32'(depth), 32'd1);
         check("tbl_cur_prio", 32'(prio), 32'(tbl[k].ch));
         check("tbl_in_irq", 32'(in_irq), 32'd1);
         check("tbl_pend_clr", 32'(pend[3'(tbl[k].ch)]), 32'd0);
         tick();
         check("tbl_take_one_cycle", 32'(take), 32'd0);
         pulse_iret();
         check("tbl_iret_depth", 32'(depth), 32'd0);
         check("tbl_iret_prio", 32'(prio), 32'hF);
         check("tbl_iret_in_irq", 32'(in_irq), 32'd0);
      end

      // Preemption: ch1 nests over ch3, ch5 waits for depth 0.
      i_irq_req = 8'h08; tick(); i_irq_req = '0;
      push(16'h001C, 4'd3); tick();
      check("pre_depth1", 32'(depth), 32'd1);
      tick();
      i_irq_req = 8'h22; tick(); i_irq_req = '0;
      push(16'h0014, 4'd1); tick();
      check("pre_take_ch1", 32'(take), 32'd1);
      check("pre_vec_ch1", 32'(vec), 32'h0014);
      check("pre_depth2", 32'(depth), 32'd2);
      check("pre_pend5", 32'(pend[5]), 32'd1);
      tick(); tick();
      check("pre_pend5_held", 32'(pend[5]), 32'd1);
      pulse_iret();
      check("pre_pop_depth", 32'(depth), 32'd1);
      check("pre_pop_prio", 32'(prio), 32'd3);
      tick(); tick();
      check("pre_ch5_blocked", 32'(pend[5]), 32'd1);
      check("pre_ch5_depth", 32'(depth), 32'd1);
      pulse_iret();
      check("pre_depth0", 32'(depth), 32'd0);
      push(16'h0024, 4'd5); tick();
      check("pre_take_ch5", 32'(take), 32'd1);
      check("pre_ch5_prio", 32'(prio), 32'd5);
      tick(); pulse_iret();

      // IRET coinciding with an eligible take: pop only, take one cycle later.
      i_irq_req = 8'h08; tick(); i_irq_req = '0;
      push(16'h001C, 4'd3); tick(); tick();
      i_irq_req = 8'h01; tick();
      i_irq_req = '0; i_iret = 1'b1; tick(); i_iret = 1'b0;
      check("co_no_take", 32'(take), 32'd0);
      check("co_depth0", 32'(depth), 32'd0);
      check("co_pend0", 32'(pend[0]), 32'd1);
      push(16'h0010, 4'd0); tick();
      check("co_take_next", 32'(take), 32'd1);
      check("co_depth1", 32'(depth), 32'd1);
      tick(); pulse_iret();
      check("err_before", 32'(iret_err), 32'd0);
      pulse_iret();
      check("err_set", 32'(iret_err), 32'd1);
      check("err_depth", 32'(depth), 32'd0);
      tick();
      check("err_sticky", 32'(iret_err), 32'd1);

      // Held request for 10 edges: one take (edge mode) or one per IRET (level mode).
      begin
         int base;
         base = take_cnt;
         i_irq_req = 8'h04;
         for (int e = 1; e <= 13; e++) begin
            if (e == 11) i_irq_req = '0;
            i_iret = MODE_IRET_AT[e];
            if (MODE_TAKE_AT[e]) push(16'h0018, 4'd2);
            tick();
         end
         i_iret = 1'b0;
         tick();
         check("mode_take_count", 32'(take_cnt - base), 32'(MODE_TAKES));
         check("mode_depth", 32'(depth), 32'd0);
      end
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      // Saturation on the MAX_DEPTH=2 instance.
      sb_en = 1'b0;
      do_reset();
      check("sat_rst_iret_err", 32'(iret_err), 32'd0);
      i_irq_req = 8'h10; tick(); i_irq_req = '0; tick();
      check("sat_take_ch4", 32'(d2_take), 32'd1);
      check("sat_vec_ch4", 32'(d2_vec), 32'h0020);
      tick();
      i_irq_req = 8'h04; tick(); i_irq_req = '0; tick();
      check("sat_take_ch2", 32'(d2_take), 32'd1);
      check("sat_depth2", 32'(d2_depth), 32'd2);
      tick();
      i_irq_req = 8'h01; tick(); i_irq_req = '0; tick();
      check("sat_no_take", 32'(d2_take), 32'd0);
      check("sat_pend0", 32'(d2_pend[0]), 32'd1);
      tick(); tick();
      check("sat_still_no_take", 32'(d2_take), 32'd0);
      check("sat_depth_held", 32'(d2_depth), 32'd2);
      pulse_iret();
      check("sat_pop_depth", 32'(d2_depth), 32'd1);
      check("sat_pop_prio", 32'(d2_prio), 32'd4);
      tick();
      check("sat_take_ch0", 32'(d2_take), 32'd1);
      check("sat_vec_ch0", 32'(d2_vec), 32'h0010);
      check("sat_prio_ch0", 32'(d2_prio), 32'd0);
      check("sat_pend0_clr", 32'(d2_pend[0]), 32'd0);

      // Reset asserted during a take cycle.
      do_reset();
      i_irq_req = 8'h08; tick(); i_irq_req = '0; tick();
      check("rmt_take_before", 32'(take), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rmt_take", 32'(take), 32'd0);
      check("rmt_vector", 32'(vec), 32'h0000);
      check("rmt_depth", 32'(depth), 32'd0);
      check("rmt_in_irq", 32'(in_irq), 32'd0);
      check("rmt_cur_prio", 32'(prio), 32'hF);
      check("rmt_pending", 32'(pend), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rmt_edge1_take", 32'(take), 32'd0);
      tick();
      check("rmt_edge2_take", 32'(take), 32'd0);
      check("rmt_edge2_depth", 32'(depth), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
